wash_program_controller: RTL
============================

# wash_program_controller

Parametrised multi-mode wash sequencer: the next-generation washing-machine controller, driving valve, detergent, motor, drain, spin and door-lock actuators through a mode-dependent program. It adds a configurable rinse count, a spin phase, a water-level sensor with fill timeout, a door interlock, and pause/resume with a frozen phase timer. It sits between the front-panel inputs and the actuator drivers; all outputs are registered.

## Interface
- TIMER_W, 16: phase timer width; every phase duration, including 3*WASH_TICKS, must fit, checked at elaboration.
- FILL_TIMEOUT, 200: maximum FILL cycles before the fault.
- WASH_TICKS, 100: base wash length; mode multiplies it by 1, 2 or 3.
- RINSE_TICKS, 60: agitation cycles per rinse.
- DRAIN_TICKS, 40: cycles per drain.
- SPIN_TICKS, 80: cycles of final spin.
- MAX_RINSE, 3: rinses in heavy mode; the rinse counter is $clog2(MAX_RINSE+1) bits wide.
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low; clears all state and outputs.
- power  in  1  0 = synchronous abort to IDLE.
- start  in  1  level; sampled in IDLE and DONE.
- pause  in  1  level; freezes the running phase.
- mode  in  2  00 quick, 01 normal, 10 heavy, 11 rinse-only; latched on start.
- door_closed  in  1  door sensor.
- water_full  in  1  level sensor; ends FILL.
- water_in, detergent, motor, drain, spin, door_lock  out  1 each  actuator enables.
- done  out  1  program complete.
- error  out  1  sticky fault.
- phase  out  3  encoded current state, for display.

## Operation
- States: IDLE, FILL, WASH, RINSE, DRAIN, SPIN, DONE, ERROR.
- IDLE → FILL when power & start & door_closed.
  - On this transition: latch mode, rinse_idx=0, load the fill timer.
  - IDLE with door open: start is ignored.
- Mode table (latched mode):
  - quick: wash = 1×WASH_TICKS, 1 rinse.
  - normal: wash = 2×WASH_TICKS, 2 rinses.
  - heavy: wash = 3×WASH_TICKS, MAX_RINSE rinses.
  - rinse-only: no wash, 1 rinse; the first fill goes straight to RINSE.
- FILL:
  - water_in=1.
  - detergent=1 only while rinse_idx==0 and mode≠rinse-only.
  - water_full → WASH if rinse_idx==0 and mode≠rinse-only; otherwise → RINSE.
  - FILL_TIMEOUT cycles without water_full → ERROR.
- WASH / RINSE: motor=1 for the programmed count, then → DRAIN.
- DRAIN:
  - drain=1 for DRAIN_TICKS.
  - Then, if rinse_idx < rinses(mode): rinse_idx++ and → FILL.
  - Otherwise → SPIN.
- SPIN: spin=1, drain=1 for SPIN_TICKS, then → DONE.
- DONE: done=1, door_lock=0; → IDLE when start==0.
- door_lock=1 in FILL, WASH, RINSE, DRAIN, SPIN and ERROR.
- Pause:
  - Applies while pause=1 in FILL through SPIN.
  - Timer frozen, state held, all actuators 0 except door_lock=1.
  - Fill-timeout count also frozen; water_full ignored.
  - Releasing pause resumes the remaining count exactly.
  - pause has no effect in IDLE, DONE and ERROR.
- ERROR: entered on fill timeout, or door_closed=0 while door_lock=1.
  - error=1, drain=1, door_lock=1, all other actuators 0.
  - Exits only via power=0 or reset, both to IDLE with error cleared.
- power=0 in any state → IDLE next edge; all outputs 0, rinse_idx and timer cleared.
- Priority, highest first: power=0 > door-open fault > pause > phase completion.

## Timing
- Reset value of every output is 0; phase = IDLE.
- start sampled at edge t → phase=FILL and water_in=1 visible after edge t.
- A phase of N ticks keeps its actuator high for exactly N clock cycles.
  - Timer loads N-1 on entry, counts down while not paused, transitions on the edge where it reads 0.
- water_full high at edge t during FILL → next phase after edge t, so FILL lasts ≥1 cycle.
- Fill timeout: ERROR after edge FILL_TIMEOUT of unpaused FILL cycles.
- Pause asserted at edge t → actuators drop after edge t; the count resumes from the same value.
- Mid-operation reset: immediate asynchronous clear, identical to the reset values.

## Structure
- wm_pkg holds:
  - state enum and its 3-bit encoding (shared with the display);
  - mode codes;
  - functions wash_len(mode) and rinses(mode).
- Sub-module phase_timer: TIMER_W down counter with load, enable (!pause) and zero flag. It is instanced twice: phase timer and fill-timeout timer.

## Test plan
Parameters for all scenarios: FILL_TIMEOUT=8, WASH_TICKS=4, RINSE_TICKS=3, DRAIN_TICKS=2, SPIN_TICKS=3, MAX_RINSE=3.
- Quick, water_full 2 cycles after FILL entry: water_in 2, wash 4, drain 2, fill, rinse 3, drain 2, spin 3, then done=1 until start drops; door_lock low only in IDLE/DONE.
- Heavy: motor high 12 cycles in WASH; 3 RINSE phases; detergent high only during the first FILL.
- Pause for 5 cycles after 2 wash cycles: motor=0, door_lock=1 while paused; total WASH motor time still 4 (normal mode: 8).
- water_full never asserted: ERROR after 8 FILL cycles, error=1, drain=1, door_lock=1; start ignored; power=0 → IDLE, error=0.
- door_closed=0 during SPIN → ERROR; power=0 during RINSE → IDLE with all outputs 0 next cycle; reset low mid-WASH → all outputs 0 immediately.
- Rinse-only: FILL → RINSE with detergent=0 and no WASH phase.

Source files
------------

// File: rtl/wm_pkg.sv
// Shared state encoding, mode codes and program-length helpers for the wash
// sequencer; the state encoding doubles as the front-panel phase display code.
package wm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_WASH  = 3'd2,
    ST_RINSE = 3'd3,
    ST_DRAIN = 3'd4,
    ST_SPIN  = 3'd5,
    ST_DONE  = 3'd6,
    ST_ERROR = 3'd7
  } state_t;

  localparam logic [1:0] MODE_QUICK  = 2'b00;
  localparam logic [1:0] MODE_NORMAL = 2'b01;
  localparam logic [1:0] MODE_HEAVY  = 2'b10;
  localparam logic [1:0] MODE_RINSE  = 2'b11;

  function automatic int unsigned wash_len(input logic [1:0] m, input int unsigned base);
    case (m)
      MODE_QUICK:  return base;
      MODE_NORMAL: return 2 * base;
      MODE_HEAVY:  return 3 * base;
      default:     return 0;
    endcase
  endfunction

  function automatic int unsigned rinses(input logic [1:0] m, input int unsigned max_rinse);
    case (m)
      MODE_NORMAL: return 2;
      MODE_HEAVY:  return max_rinse;
      default:     return 1;
    endcase
  endfunction

  function automatic logic is_active(input state_t s);
    return (s == ST_FILL) || (s == ST_WASH) || (s == ST_RINSE) ||
           (s == ST_DRAIN) || (s == ST_SPIN);
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down counter that parks at zero; enable low freezes the count.
module phase_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                   cnt <= '0;
    else if (load)                cnt <= load_val;
    else if (en && cnt != '0)     cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/wash_program_controller.sv
// Multi-mode wash sequencer: FILL/WASH/RINSE/DRAIN/SPIN program with door
// interlock, fill timeout and pause; all actuator outputs are registered.
module wash_program_controller
  import wm_pkg::*;
#(
  parameter int TIMER_W      = 16,
  parameter int FILL_TIMEOUT = 200,
  parameter int WASH_TICKS   = 100,
  parameter int RINSE_TICKS  = 60,
  parameter int DRAIN_TICKS  = 40,
  parameter int SPIN_TICKS   = 80,
  parameter int MAX_RINSE    = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       power,
  input  logic       start,
  input  logic       pause,
  input  logic [1:0] mode,
  input  logic       door_closed,
  input  logic       water_full,
  output logic       water_in,
  output logic       detergent,
  output logic       motor,
  output logic       drain,
  output logic       spin,
  output logic       door_lock,
  output logic       done,
  output logic       error,
  output logic [2:0] phase
);

  localparam int RW = $clog2(MAX_RINSE + 1);
  localparam longint TMAX = (longint'(1) << TIMER_W) - 1;

  if (longint'(3 * WASH_TICKS) > TMAX || longint'(FILL_TIMEOUT) > TMAX ||
      longint'(RINSE_TICKS) > TMAX || longint'(DRAIN_TICKS) > TMAX ||
      longint'(SPIN_TICKS) > TMAX) begin : g_bad_cfg
    $error("wash_program_controller: a phase duration does not fit in TIMER_W bits");
  end

  state_t              state, nxt;
  logic [1:0]          mode_q, nxt_mode;
  logic [RW-1:0]       rinse_idx, nxt_idx;
  logic                ph_load, fl_load, ph_zero, fl_zero;
  logic [TIMER_W-1:0]  ph_val, fl_val;
  logic                more_rinse, hold;

  // Rinse-only skips the wash, so its first FILL already feeds a rinse.
  assign more_rinse = (32'(rinse_idx) + 32'(mode_q == MODE_RINSE)) <
                      rinses(mode_q, MAX_RINSE);
  assign hold = pause && is_active(state) && (nxt == state);
  assign phase = state;

  phase_timer #(.W(TIMER_W)) u_phase_tmr (
    .clk(clk), .reset(reset), .load(ph_load), .en(!pause),
    .load_val(ph_val), .zero(ph_zero));

  phase_timer #(.W(TIMER_W)) u_fill_tmr (
    .clk(clk), .reset(reset), .load(fl_load), .en(!pause),
    .load_val(fl_val), .zero(fl_zero));

  always_comb begin
    nxt      = state;
    nxt_mode = mode_q;
    nxt_idx  = rinse_idx;
    ph_load  = 1'b0;
    ph_val   = '0;
    fl_load  = 1'b0;
    fl_val   = '0;
    if (!power) begin
      nxt     = ST_IDLE;
      nxt_idx = '0;
      ph_load = 1'b1;
      fl_load = 1'b1;
    end else if (door_lock && !door_closed) begin
      nxt = ST_ERROR;
    end else if (pause && is_active(state)) begin
      nxt = state;
    end else begin
      case (state)
        ST_IDLE: if (start && door_closed) begin
          nxt      = ST_FILL;
          nxt_mode = mode;
          nxt_idx  = '0;
          fl_load  = 1'b1;
          fl_val   = TIMER_W'(FILL_TIMEOUT - 1);
        end
        ST_FILL: if (water_full) begin
          ph_load = 1'b1;
          if (rinse_idx == '0 && mode_q != MODE_RINSE) begin
            nxt    = ST_WASH;
            ph_val = TIMER_W'(wash_len(mode_q, WASH_TICKS) - 1);
          end else begin
            nxt    = ST_RINSE;
            ph_val = TIMER_W'(RINSE_TICKS - 1);
          end
        end else if (fl_zero) begin
          nxt = ST_ERROR;
        end
        ST_WASH, ST_RINSE: if (ph_zero) begin
          nxt     = ST_DRAIN;
          ph_load = 1'b1;
          ph_val  = TIMER_W'(DRAIN_TICKS - 1);
        end
        ST_DRAIN: if (ph_zero) begin
          if (more_rinse) begin
            nxt     = ST_FILL;
            nxt_idx = rinse_idx + 1'b1;
            fl_load = 1'b1;
            fl_val  = TIMER_W'(FILL_TIMEOUT - 1);
          end else begin
            nxt     = ST_SPIN;
            ph_load = 1'b1;
            ph_val  = TIMER_W'(SPIN_TICKS - 1);
          end
        end
        ST_SPIN: if (ph_zero) nxt = ST_DONE;
        ST_DONE: if (!start)  nxt = ST_IDLE;
        default: nxt = state;
      endcase
    end
  end

  // Outputs decode the next state so they change on the same edge as phase.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      mode_q    <= MODE_QUICK;
      rinse_idx <= '0;
      water_in  <= 1'b0;
      detergent <= 1'b0;
      motor     <= 1'b0;
      drain     <= 1'b0;
      spin      <= 1'b0;
      door_lock <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      state     <= nxt;
      mode_q    <= nxt_mode;
      rinse_idx <= nxt_idx;
      water_in  <= (nxt == ST_FILL) && !hold;
      detergent <= (nxt == ST_FILL) && !hold && (nxt_idx == '0) && (nxt_mode != MODE_RINSE);
      motor     <= ((nxt == ST_WASH) || (nxt == ST_RINSE)) && !hold;
      drain     <= (((nxt == ST_DRAIN) || (nxt == ST_SPIN)) && !hold) || (nxt == ST_ERROR);
      spin      <= (nxt == ST_SPIN) && !hold;
      door_lock <= is_active(nxt) || (nxt == ST_ERROR);
      done      <= (nxt == ST_DONE);
      error     <= (nxt == ST_ERROR);
    end
  end

endmodule
